// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : Pipeline stage register with a valid/ready handshake and a
//                two-entry (main + skid) buffer. It replaces the fixed-width
//                inter-stage registers and keeps their debug freeze and debug
//                clear controls. It also provides a synchronous flush and
//                forces the control bits to zero on bubbles.
//
//                inReady depends only on registered skid state and on
//                debugEnable. No combinational path runs from outReady to
//                inReady.
//
//  Parameters  : DATA_W - payload width
//                CTRL_W - control-bit width (zeroed when outValid=0)
//
//  Ports       : clock, reset           - clock, sync active-high reset
//                debugEnable            - 1 = run, 0 = freeze
//                debugReset             - sync debug clear (same as reset)
//                flush                  - sync flush, drops both entries
//                inValid/inReady        - upstream handshake
//                inData/inCtrl/inEop    - upstream beat
//                outValid/outReady      - downstream handshake
//                outData/outCtrl/outEop - main-entry beat
//                xferCount/stallCount   - performance counters
//
//  Macro       : PIPE_STAGE_PERF_EN - when defined, the counters are built.
//                When it is undefined, both counter ports read 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              debugEnable,
    input  logic              debugReset,
    input  logic              flush,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] inData,
    input  logic [CTRL_W-1:0] inCtrl,
    input  logic              inEop,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outData,
    output logic [CTRL_W-1:0] outCtrl,
    output logic              outEop,
    output logic [31:0]       xferCount,
    output logic [31:0]       stallCount
);

    logic              r_mainValid;
    logic [DATA_W-1:0] r_mainData;
    logic [CTRL_W-1:0] r_mainCtrl;
    logic              r_mainEop;

    logic              r_skidValid;
    logic [DATA_W-1:0] r_skidData;
    logic [CTRL_W-1:0] r_skidCtrl;
    logic              r_skidEop;

    logic w_accept;
    logic w_release;
    logic w_clear;

    assign w_clear   = reset | debugReset;
    assign inReady   = ~r_skidValid & debugEnable;
    assign outValid  = r_mainValid & debugEnable;
    assign w_accept  = inValid & inReady & debugEnable;
    assign w_release = outValid & outReady;

    // Data is passed through raw. Only ctrl and eop are masked, so that a
    // bubble cannot assert a write enable or an end-of-program downstream.
    assign outData = r_mainData;
    assign outCtrl = outValid ? r_mainCtrl : '0;
    assign outEop  = outValid & r_mainEop;

    always_ff @(posedge clock) begin
        if (w_clear) begin
            r_mainValid <= 1'b0;
            r_mainData  <= '0;
            r_mainCtrl  <= '0;
            r_mainEop   <= 1'b0;
            r_skidValid <= 1'b0;
            r_skidData  <= '0;
            r_skidCtrl  <= '0;
            r_skidEop   <= 1'b0;
        end else if (flush) begin
            // A beat accepted in this cycle is dropped. Upstream still sees
            // it as consumed.
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (debugEnable) begin
            if (!r_mainValid || w_release) begin
                if (r_skidValid) begin
                    // inReady is low while skid is valid, so no accept can
                    // collide with this move.
                    r_mainValid <= 1'b1;
                    r_mainData  <= r_skidData;
                    r_mainCtrl  <= r_skidCtrl;
                    r_mainEop   <= r_skidEop;
                    r_skidValid <= 1'b0;
                end else if (w_accept) begin
                    r_mainValid <= 1'b1;
                    r_mainData  <= inData;
                    r_mainCtrl  <= inCtrl;
                    r_mainEop   <= inEop;
                end else begin
                    r_mainValid <= 1'b0;
                end
            end else if (w_accept) begin
                // Main is stalled. The beat that was already promised by the
                // registered inReady lands in the skid entry.
                r_skidValid <= 1'b1;
                r_skidData  <= inData;
                r_skidCtrl  <= inCtrl;
                r_skidEop   <= inEop;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] r_xferCount;
    logic [31:0] r_stallCount;

    // outValid already includes debugEnable, so freeze holds both counters.
    // Flush does not gate the counters.
    always_ff @(posedge clock) begin
        if (w_clear) begin
            r_xferCount  <= '0;
            r_stallCount <= '0;
        end else begin
            if (w_release) begin
                r_xferCount <= r_xferCount + 32'd1;
            end
            if (outValid && !outReady) begin
                r_stallCount <= r_stallCount + 32'd1;
            end
        end
    end

    assign xferCount  = r_xferCount;
    assign stallCount = r_stallCount;
`else
    assign xferCount  = '0;
    assign stallCount = '0;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It is the next-generation replacement for the fixed-width inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It keeps the debug freeze and debug clear controls of those registers, and adds:
- backpressure without combinational ready paths,
- a synchronous flush for hazard and branch bubbles,
- bubble-safe zeroing of control bits.

## Interface
Parameters:
- DATA_W, 32, payload width (ALU result, memory data, write-register index, concatenated by the instantiating stage)
- CTRL_W, 8, control-bit width (regWrite, memToReg and similar); forced to 0 whenever the output is a bubble

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- debugEnable  in  1  1 = run; 0 = freeze (no accept, no release, state held)
- debugReset  in  1  synchronous debug clear, equivalent to reset for this block
- flush  in  1  synchronous pipeline flush; discards both entries
- inValid  in  1  upstream beat valid
- inReady  out  1  stage can accept; registered
- inData  in  DATA_W  upstream payload
- inCtrl  in  CTRL_W  upstream control bits
- inEop  in  1  end-of-program marker
- outValid  out  1  downstream beat valid
- outReady  in  1  downstream can take the beat
- outData  out  DATA_W  payload of the main entry
- outCtrl  out  CTRL_W  control bits of the main entry; 0 when outValid=0
- outEop  out  1  eop of the main entry; 0 when outValid=0
- xferCount  out  32  number of completed output transfers
- stallCount  out  32  number of cycles with outValid=1 and outReady=0

## Operation
- Storage: one main entry and one skid entry. Each entry holds valid, data, ctrl and eop.
- Defined terms:
  - accept = inValid & inReady & debugEnable
  - release = outValid & outReady
- inReady = !skidValid & debugEnable. The skid-valid part is registered state, so there is no path from outReady to inReady.
- outValid = mainValid & debugEnable.
- Priority: reset > debugReset > flush > freeze (debugEnable=0) > normal.
- Normal update, main entry empty or releasing:
  - skid valid: main <- skid, skid <- empty.
  - skid empty and accept: main <- input.
  - otherwise: main <- empty.
- Normal update, main entry holding (valid, not released):
  - accept: skid <- input.
  - otherwise: skid unchanged.
- Bubble zeroing: outData is unspecified when outValid=0, but outCtrl and outEop read 0.
- flush: both entries are invalidated. A beat accepted in the same cycle as flush is discarded; upstream treats it as consumed. Counters are not affected.
- reset / debugReset: both entries are invalidated and every data field is cleared to 0. Counters are cleared when compiled in.
- Freeze (debugEnable=0):
  - inReady=0 and outValid=0.
  - Entries and counters are held.
  - The held beat reappears unchanged when debugEnable returns to 1.

## Timing
- Reset values: inReady=1 (first cycle after reset with debugEnable=1), outValid=0, outData=0, outCtrl=0, outEop=0, xferCount=0, stallCount=0.
- Latency: a beat accepted at edge N is presented on out* after edge N (1 cycle).
- Throughput: 1 beat/cycle while outReady=1.
- Backpressure:
  - With outReady=0 and the main entry full, one further beat is absorbed into the skid entry.
  - inReady falls after that edge.
  - inReady rises again after the edge at which the skid entry moves into main.
- No beat is lost or duplicated across any outReady pattern.
- Beats leave in the order they were accepted.

## Configuration
- PIPE_STAGE_PERF_EN defined: xferCount increments on every release and stallCount increments on every cycle with outValid & !outReady. Both are 32-bit and wrap from 0xFFFFFFFF to 0. Both are cleared by reset and debugReset, held by freeze, and unaffected by flush.
- PIPE_STAGE_PERF_EN undefined: both counter ports remain and are tied to 0; no counter flops are synthesised.

## Test plan
- Reset, then 4 beats with data 0x11..0x44 and outReady=1 -> each beat appears 1 cycle later, in order; inReady stays 1; xferCount=4 (PERF on).
- Hold outReady=0 and send beats 0xA, 0xB, 0xC -> 0xA is in main, 0xB in skid, inReady=0 and 0xC is not accepted. Raise outReady -> out sequence is 0xA, 0xB, 0xC; stallCount equals the cycles spent held.
- Main and skid both full with ctrl=0xFF, assert flush for one cycle -> outValid=0, outCtrl=0, outEop=0, inReady=1 on the next cycle; a beat presented during the flush cycle never appears.
- Beat 0x55 in main, debugEnable=0 for 5 cycles with outReady=1 -> outValid=0, inReady=0, counters frozen. Set debugEnable=1 -> 0x55 is released once.
- debugReset asserted with main and skid full and xferCount=7 -> all outputs return to reset values and xferCount=0. Separately, reset and flush asserted together -> reset values apply.
- PERF off build -> xferCount and stallCount read 0 throughout the first scenario.
